// File: rtl/calc_display_driver_if.sv
// rtl/calc_display_driver_if.sv - value/format command and segment/anode drive bundle for the display driver
interface calc_display_driver_if;
    logic [15:0] value;
    logic        load;
    logic        format;
    logic [6:0]  segments;
    logic [7:0]  anodes;
    logic        busy;

    modport master (
        output value, load, format,
        input  segments, anodes, busy
    );

    modport slave (
        input  value, load, format,
        output segments, anodes, busy
    );
endinterface

// File: rtl/calc_display_driver.sv
// rtl/calc_display_driver.sv - 8-digit multiplexed 7-segment driver with hex or double-dabble decimal display
module calc_display_driver #(
    parameter int COUNT_MAX = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    calc_display_driver_if.slave  io
);

    localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } conv_state_t;

    conv_state_t    state_q, state_d;
    logic [15:0]    value_q, value_d;
    logic [35:0]    shift_q, shift_d;
    logic [4:0]     iter_q, iter_d;
    logic [19:0]    bcd_q, bcd_d;
    logic [CW-1:0]  refresh_q;
    logic [2:0]     idx_q;
    logic [6:0]     seg_q, seg_d;
    logic [7:0]     an_q, an_d;

    // One double-dabble iteration: correct each BCD nibble, then shift in the next binary bit.
    function automatic logic [35:0] dabble_step(input logic [35:0] s);
        logic [35:0] t;
        t = s;
        for (int i = 0; i < 5; i++) begin
            if (t[16 + 4*i +: 4] >= 4'd5) begin
                t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[34:0], 1'b0};
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            value_q <= 16'd0;
            shift_q <= 36'd0;
            iter_q  <= 5'd0;
            bcd_q   <= 20'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
        end
    end

    // A load always wins, so a load mid-conversion restarts from the new value.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        if (io.load) begin
            state_d = S_CONV;
            value_d = io.value;
            shift_d = {20'd0, io.value};
            iter_d  = 5'd16;
        end else if (state_q == S_CONV) begin
            shift_d = dabble_step(shift_q);
            iter_d  = iter_q - 5'd1;
            if (iter_q == 5'd1) begin
                bcd_d   = shift_d[35:16];
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            idx_q     <= 3'd0;
        end else if (refresh_q == CW'(COUNT_MAX - 1)) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 3'd1;
        end else begin
            refresh_q <= refresh_q + CW'(1);
        end
    end

    logic [19:0] bcd_upper;
    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic        blank;

    always_comb begin
        bcd_upper = bcd_q >> {idx_q, 2'b00};
        nib       = 4'd0;
        glyph     = 7'b1111111;
        blank     = 1'b1;
        if (idx_q == 3'd7) begin
            glyph = io.format ? 7'b0100001 : 7'b0001001;
            blank = 1'b0;
        end else if (!io.format) begin
            if (idx_q <= 3'd3) begin
                nib   = value_q[{idx_q[1:0], 2'b00} +: 4];
                glyph = hex_glyph(nib);
                blank = 1'b0;
            end
        end else if (idx_q <= 3'd4) begin
            nib   = bcd_upper[3:0];
            glyph = hex_glyph(nib);
            // Leading-zero suppression: blank when this digit and all above it are zero.
            blank = (idx_q != 3'd0) && (bcd_upper == 20'd0);
        end

        seg_d = 7'b1111111;
        an_d  = 8'hFF;
        if (!blank) begin
            seg_d = glyph;
            an_d  = ~(8'd1 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 7'b1111111;
            an_q  <= 8'hFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign io.segments = seg_q;
    assign io.anodes   = an_q;
    assign io.busy     = (state_q == S_CONV);

endmodule

// File: tb/tb_calc_display_driver.sv
// tb/tb_calc_display_driver.sv - randomized self-checking bench for calc_display_driver against a digit-level model
module tb_calc_display_driver;

    localparam int CM = 4;

    logic clk;
    logic reset;
    calc_display_driver_if bus ();

    calc_display_driver #(.COUNT_MAX(CM)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] glyphs [16];
    initial begin
        glyphs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    end

    int   m_hex, m_dec, m_pend, m_left, m_tick;
    logic cur_fmt;

    task automatic tick(input logic rst, input logic ld, input logic [15:0] v);
        logic [6:0] exp_seg;
        logic [7:0] exp_an;
        int         k, pw;
        reset      = rst;
        bus.load   = ld;
        bus.value  = v;
        bus.format = cur_fmt;
        @(posedge clk);
        exp_seg = 7'h7F;
        exp_an  = 8'hFF;
        if (rst) begin
            m_hex = 0; m_dec = 0; m_left = 0; m_tick = 0;
        end else begin
            k = (m_tick / CM) % 8;
            if (k == 7) begin
                exp_seg = cur_fmt ? 7'b0100001 : 7'b0001001;
                exp_an  = 8'h7F;
            end else if (!cur_fmt) begin
                if (k < 4) begin
                    exp_seg = glyphs[(m_hex >> (4 * k)) & 15];
                    exp_an  = ~(8'd1 << k);
                end
            end else if (k < 5) begin
                pw = 1;
                for (int j = 0; j < k; j++) pw = pw * 10;
                if (k == 0 || m_dec >= pw) begin
                    exp_seg = glyphs[(m_dec / pw) % 10];
                    exp_an  = ~(8'd1 << k);
                end
            end
            m_tick++;
            if (ld) begin
                m_hex  = int'(v);
                m_pend = int'(v);
                m_left = 16;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_dec = m_pend;
            end
        end
        @(negedge clk);
        check_eq("segments", 32'(bus.segments), 32'(exp_seg));
        check_eq("anodes", 32'(bus.anodes), 32'(exp_an));
        check_eq("busy", 32'(bus.busy), 32'(m_left > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'd0);
    endtask

    initial begin
        cur_fmt = 1'b0;
        m_hex = 0; m_dec = 0; m_pend = 0; m_left = 0; m_tick = 0;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'd0);
        idle(40);

        tick(1'b0, 1'b1, 16'h1234);
        idle(40);

        cur_fmt = 1'b1;
        tick(1'b0, 1'b1, 16'd65535);
        idle(60);

        tick(1'b0, 1'b1, 16'd7);
        idle(50);

        tick(1'b0, 1'b1, 16'd100);
        idle(3);
        tick(1'b0, 1'b1, 16'd42);
        idle(60);

        tick(1'b0, 1'b1, 16'd9999);
        idle(7);
        tick(1'b1, 1'b0, 16'd0);
        idle(40);

        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 29) == 0) cur_fmt = ~cur_fmt;
            tick(r < 1, (r >= 1) && (r < 7), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_display_driver.md
CALC_DISPLAY_DRIVER -- requirements
Module: calc_display_driver

Interface
REQ-001 Parameter COUNT_MAX, default 100000, SHALL set the clock cycles each digit stays active before the scan advances.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 value  input  16  SHALL be the unsigned value to display, sampled only when load=1.
REQ-005 load  input  1  SHALL be a single-cycle strobe that captures value and starts the decimal conversion.
REQ-006 format  input  1  SHALL select display mode: 0=hexadecimal, 1=decimal.
REQ-007 segments  output  7  SHALL be the active-low segment drive, bit order {g,f,e,d,c,b,a}.
REQ-008 anodes  output  8  SHALL be the active-low one-hot digit enable, with bit k driving digit k and digit 0 rightmost.
REQ-009 busy  output  1  SHALL be high while the binary-to-BCD conversion runs.

Function
REQ-010 On a load edge, the value register SHALL capture value, the shift register SHALL be {20'b0, value}, the iteration counter SHALL be 16, and busy SHALL go to 1.
REQ-011 Each busy cycle SHALL add 3 to every BCD nibble >=5, then shift left 1 and decrement the counter, giving 1 shift/cycle (double-dabble).
REQ-012 On the 16th shift edge, the 20-bit BCD register SHALL update and busy SHALL go to 0, so busy is high exactly 16 cycles after the load edge.
REQ-013 The BCD register SHALL hold its previous result during conversion, so decimal digits show no intermediate values.
REQ-014 A load while busy SHALL abort the current conversion and restart it per REQ-010 with the new value.
REQ-015 Conversion SHALL run regardless of format, and a format change SHALL need no reconversion.
REQ-016 The refresh counter SHALL count 0..COUNT_MAX-1 and wrap; on wrap, the digit index SHALL increment modulo 8.
REQ-017 segments and anodes SHALL be registered and derived from the current digit index, giving 1 cycle latency from index change.
REQ-018 The active digit SHALL drive anodes[idx]=0; blank positions SHALL drive anodes all 1s and segments=7'b1111111.
REQ-019 In hex mode, digits 0..3 SHALL show value[3:0]..value[15:12] with leading zeros shown, and digits 4..6 SHALL be blank.
REQ-020 In decimal mode, digits 0..4 SHALL show BCD units..ten-thousands and digits 5..6 SHALL be blank.
REQ-021 In decimal mode, digit k>0 SHALL be blank when it and all higher BCD digits are zero, and digit 0 SHALL always be shown.
REQ-022 Digit 7 SHALL show 'H' (0001001) in hex mode and 'd' (0100001) in decimal mode.
REQ-023 The glyph table SHALL use standard hex glyphs, including 0=1000000, 5=0010010, 7=1111000, 8=0000000, A=0001000, F=0001110.
REQ-024 format SHALL take effect on the next registered output update.

Reset
REQ-025 When reset=1, the block SHALL set value register=0, BCD=0, counter=0, busy=0, refresh counter=0, idx=0, segments=7'b1111111, anodes=8'hFF.
REQ-026 reset SHALL override load, and a reset mid-conversion SHALL discard the conversion with no BCD update.
REQ-027 After reset release, the first output update SHALL drive digit 0.

Verification (COUNT_MAX=4)
REQ-028 Reset for 3 cycles -> segments=7F, anodes=FF, busy=0; after release with format=0 -> anodes=FE, segments=1000000.
REQ-029 Load 16'h1234, format=0 -> digits 0..3 show 4,3,2,1 (digit 0 = 0011001), digit 7 shows 'H', and anodes never go low for digits 4..6.
REQ-030 Load 65535, format=1 -> busy=1 for exactly 16 cycles, then digits 4..0 = 6,5,5,3,5 and digit 7 = 'd'.
REQ-031 Load 7, format=1 -> digit 0 = 1111000 and digits 1..6 are blank (anodes stay high).
REQ-032 Load 100 then load 42 four cycles later -> busy stays high 16 cycles after the second load, and the display never shows 100, only 42.
REQ-033 Load 9999, format=1, then reset on the 8th busy cycle -> busy=0 and a decimal display of '0' next scan.
